// File: rtl/aes_cipher_round_if.sv
// -----------------------------------------------------------------------------
// aes_cipher_round_if
// Request/result bundle of the iterative AES-128 cipher datapath.
//   start       request to encrypt the presented plaintext
//   plaintext   128-bit input block, byte 0 in bits [127:120], column-major
//   key         round-0 (whitening) key
//   roundkeys   round keys 1..10, round 1 in [1279:1152], round 10 in [127:0]
//   ciphertext  128-bit result, valid with finish and held afterwards
//   busy        encryption in progress
//   finish      one-cycle pulse marking ciphertext valid
// master: the block driving requests (key schedule / testbench)
// slave : the cipher datapath
// -----------------------------------------------------------------------------
interface aes_cipher_round_if;
   logic          start;
   logic [127:0]  plaintext;
   logic [127:0]  key;
   logic [1279:0] roundkeys;
   logic [127:0]  ciphertext;
   logic          busy;
   logic          finish;

   modport master (
      output start, plaintext, key, roundkeys,
      input  ciphertext, busy, finish
   );

   modport slave (
      input  start, plaintext, key, roundkeys,
      output ciphertext, busy, finish
   );
endinterface

// File: rtl/aes_cipher_round.sv
// -----------------------------------------------------------------------------
// aes_cipher_round
// Iterative AES-128 encryption datapath. One 128-bit state register; every
// ROUND cycle applies SubBytes, ShiftRows, MixColumns (skipped in round 10)
// and AddRoundKey. Round keys come precomputed from the key schedule.
// Ports:
//   clk     clock, all updates on the rising edge
//   rst     synchronous active-high reset
//   io_aes  aes_cipher_round_if.slave (start/plaintext/key/roundkeys in,
//           ciphertext/busy/finish out)
// Build option:
//   AES_TWO_ROUND_EN  two round datapaths in series, two rounds per cycle
//                     (finish 6 cycles after acceptance instead of 11).
// -----------------------------------------------------------------------------
module aes_cipher_round #(
   parameter int NR = 10
) (
   input logic                clk,
   input logic                rst,
   aes_cipher_round_if.slave  io_aes
);

   typedef enum logic [1:0] {IDLE, ROUND, FIN} state_t;

`ifdef AES_TWO_ROUND_EN
   localparam logic [3:0] CNT_STEP = 4'd2;
   localparam logic [3:0] LAST_CNT = 4'(NR - 1);
`else
   localparam logic [3:0] CNT_STEP = 4'd1;
   localparam logic [3:0] LAST_CNT = 4'(NR);
`endif

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] f_sbox(input logic [7:0] a);
      // (255 - a) * 8 selects entry a counted from the MSB end
      return SBOX_TBL[{~a, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] f_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // One AES round; byte 4*c+r is row r of column c, byte 0 is the MSB.
   function automatic logic [127:0] f_round(input logic [127:0] s,
                                            input logic [127:0] rk,
                                            input logic         mix);
      logic [0:15][7:0] b_in;
      logic [0:15][7:0] b_sr;
      logic [0:15][7:0] b_out;
      b_in = s;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            b_sr[4*c + r] = f_sbox(b_in[4*((c + r) % 4) + r]);
         end
      end
      b_out = b_sr;
      if (mix) begin
         // b_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3)
         for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
               b_out[4*c + r] = f_xtime(b_sr[4*c + r])
                              ^ f_xtime(b_sr[4*c + (r + 1) % 4]) ^ b_sr[4*c + (r + 1) % 4]
                              ^ b_sr[4*c + (r + 2) % 4] ^ b_sr[4*c + (r + 3) % 4];
            end
         end
      end
      return b_out ^ rk;
   endfunction

   state_t         r_fsm;
   logic [3:0]     r_cnt;
   logic [127:0]   r_state;
   logic [127:0]   r_cipher;
   logic           r_busy;
   logic           r_finish;

   // w_rks[9] is round 1, w_rks[0] is round 10, so round k sits at NR-k.
   logic [9:0][127:0] w_rks;
   logic [3:0]        w_rk_idx;
   logic [127:0]      w_next;

   assign w_rks    = io_aes.roundkeys;
   assign w_rk_idx = 4'(NR) - r_cnt;

`ifdef AES_TWO_ROUND_EN
   logic [127:0] w_mid;
   assign w_mid  = f_round(r_state, w_rks[w_rk_idx], r_cnt != 4'(NR));
   assign w_next = f_round(w_mid, w_rks[w_rk_idx - 4'd1], (r_cnt + 4'd1) != 4'(NR));
`else
   assign w_next = f_round(r_state, w_rks[w_rk_idx], r_cnt != 4'(NR));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm    <= IDLE;
         r_cnt    <= '0;
         r_state  <= '0;
         r_cipher <= '0;
         r_busy   <= 1'b0;
         r_finish <= 1'b0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (io_aes.start) begin
                  r_state <= io_aes.plaintext ^ io_aes.key;
                  r_cnt   <= 4'd1;
                  r_busy  <= 1'b1;
                  r_fsm   <= ROUND;
               end
            end
            ROUND: begin
               r_state <= w_next;
               if (r_cnt == LAST_CNT) begin
                  r_cipher <= w_next;
                  r_cnt    <= '0;
                  r_finish <= 1'b1;
                  r_fsm    <= FIN;
               end else begin
                  r_cnt <= r_cnt + CNT_STEP;
               end
            end
            FIN: begin
               // start is deliberately not sampled here
               r_finish <= 1'b0;
               r_busy   <= 1'b0;
               r_fsm    <= IDLE;
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end

   assign io_aes.ciphertext = r_cipher;
   assign io_aes.busy       = r_busy;
   assign io_aes.finish     = r_finish;

endmodule

// File: tb/tb_aes_cipher_round.sv
// -----------------------------------------------------------------------------
// tb_aes_cipher_round
// Self-checking bench for aes_cipher_round. A reference AES-128 model (S-box
// derived from the GF(2^8) inverse, generic field multiply, matrix MixColumns)
// and a cycle-level acceptance/timing model predict busy, finish and
// ciphertext every cycle. Honours AES_TWO_ROUND_EN for the latency.
// -----------------------------------------------------------------------------
module tb_aes_cipher_round;

`ifdef AES_TWO_ROUND_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 11;
`endif

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk;
   logic rst;

   aes_cipher_round_if bus_if ();

   aes_cipher_round dut (
      .clk    (clk),
      .rst    (rst),
      .io_aes (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           n_checks;
   int           n_errors;
   int           cyc;
   int           last_acc;
   logic [127:0] exp_ct;
   logic [127:0] pending;
   logic [7:0]   sbox_m [256];

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] p;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [1279:0] expand_key(input logic [127:0] k);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1279:0] rks;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 1; r <= 10; r++)
         rks[1279 - 128*(r-1) -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return rks;
   endfunction

   function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] k);
      logic [1279:0] rks;
      logic [127:0]  rk;
      logic [127:0]  res;
      logic [7:0]    st  [4][4];
      logic [7:0]    tmp [4][4];
      logic [7:0]    coef [4];
      coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      rks  = expand_key(k);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            st[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ k[127 - 8*(4*c + r) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         rk = rks[1279 - 128*(rnd-1) -: 128];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               tmp[r][c] = sbox_m[st[r][(c + r) % 4]];
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               if (rnd < 10) begin
                  st[r][c] = 8'h00;
                  for (int i = 0; i < 4; i++)
                     st[r][c] = st[r][c] ^ gmul(coef[(i - r + 4) % 4], tmp[i][c]);
               end else begin
                  st[r][c] = tmp[r][c];
               end
               st[r][c] = st[r][c] ^ rk[127 - 8*(4*c + r) -: 8];
            end
         end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127 - 8*(4*c + r) -: 8] = st[r][c];
      return res;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: drive start/rst, compare outputs with the timing model,
   // advance the model, move to just after the next rising edge.
   task automatic step(input logic st, input logic rs);
      logic busy_e;
      logic fin_e;
      bus_if.start = st;
      rst          = rs;
      busy_e = (cyc - last_acc >= 1) && (cyc - last_acc <= LAT);
      fin_e  = (cyc - last_acc == LAT);
      if (fin_e) exp_ct = pending;
      chk("busy", 128'(bus_if.busy), 128'(busy_e));
      chk("finish", 128'(bus_if.finish), 128'(fin_e));
      chk("ciphertext", bus_if.ciphertext, exp_ct);
      if (rs) begin
         last_acc = -1000;
         exp_ct   = '0;
      end else if (st && !busy_e) begin
         last_acc = cyc;
         pending  = ref_enc(bus_if.plaintext, bus_if.key);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic set_inputs(input logic [127:0] pt, input logic [127:0] k);
      bus_if.plaintext = pt;
      bus_if.key       = k;
      bus_if.roundkeys = expand_key(k);
   endtask

   task automatic drain();
      for (int i = 0; i < LAT + 3; i++) step(1'b0, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      last_acc = -1000;
      exp_ct   = '0;
      pending  = '0;
      build_sbox();
      bus_if.start = 1'b0;
      set_inputs(PT_B, KEY_B);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // reset state, then FIPS-197 App. B single block
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      drain();
      chk("fipsB", bus_if.ciphertext, CT_B);

      // extra start pulses while busy are ignored
      step(1'b1, 1'b0);
      for (int c = 1; c <= LAT + 2; c++) step(1'(c == 3 || c == 7), 1'b0);
      drain();
      chk("fipsB_restart", bus_if.ciphertext, CT_B);

      // reset in the middle of a run aborts it
      step(1'b1, 1'b0);
      for (int c = 1; c <= 4; c++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      chk("abort_busy", 128'(bus_if.busy), 128'(0));
      chk("abort_ct", bus_if.ciphertext, 128'(0));
      drain();

      // FIPS-197 App. C.1 after the abort
      set_inputs(PT_C, KEY_C);
      step(1'b1, 1'b0);
      drain();
      chk("fipsC", bus_if.ciphertext, CT_C);

      // start held high: back-to-back blocks
      set_inputs(PT_B, KEY_B);
      for (int c = 0; c < 30; c++) step(1'b1, 1'b0);
      drain();
      chk("fipsB_hold", bus_if.ciphertext, CT_B);

      // randomized blocks with random start noise
      for (int b = 0; b < 6; b++) begin
         set_inputs({$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom});
         step(1'b1, 1'b0);
         for (int c = 0; c < LAT + 2; c++) step(1'($urandom_range(0, 1)), 1'b0);
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
